load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  execute stage presents a memory op.
REQ-005 SHALL have port req_ready  out  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_is_store  in  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  in  3  RV32I width/sign code.
REQ-008 SHALL have port req_addr  in  WIDTH  byte address (ALU result).
REQ-009 SHALL have port req_wdata  in  WIDTH  store data (rs2).
REQ-010 SHALL have port req_rd  in  5  load destination register.
REQ-011 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out WIDTH (word-aligned), mem_wstrb out WIDTH/8, mem_wdata out WIDTH: data-memory request.
REQ-012 SHALL have ports mem_ack in 1 (access complete), mem_rdata in WIDTH (read word, valid with mem_ack).
REQ-013 SHALL have ports resp_valid out 1, resp_we out 1, resp_rd out 5, resp_data out WIDTH: writeback result.
REQ-014 SHALL have port fault  out  1  one-cycle pulse on misaligned or illegal request.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP, FAULT.
REQ-016 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; all req_* captured on handshake.
REQ-017 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code is illegal.
REQ-018 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-019 IDLE + handshake + (illegal or misaligned) SHALL go to FAULT; no mem_req issued.
REQ-020 IDLE + handshake + legal aligned SHALL go to ACCESS.
REQ-021 FAULT SHALL assert fault=1 for exactly one cycle, resp_valid=0, then return to IDLE.
REQ-022 ACCESS SHALL hold mem_req=1 and all mem_* stable until the cycle mem_ack=1, then go to RESP.
REQ-023 mem_addr SHALL be {addr[WIDTH-1:2],2'b00}; mem_we = is_store.
REQ-024 Stores: SB replicates byte 4x, wstrb = 0001<<addr[1:0]; SH replicates halfword 2x, wstrb = 0011<<addr[1:0]; SW wstrb=1111, data unchanged.
REQ-025 Loads: mem_wstrb=0000; byte/halfword lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-026 Load data SHALL be registered on the mem_ack cycle.
REQ-027 RESP SHALL assert resp_valid=1 for exactly one cycle, then IDLE; loads: resp_we=1, resp_rd=captured rd, resp_data=extended value; stores: resp_we=0, resp_rd=0, resp_data=0.
REQ-028 Latency: handshake at cycle N, mem_req from N+1, ack at cycle M>=N+1 -> resp_valid at M+1; back-to-back requests accepted no earlier than M+2.
REQ-029 mem_ack outside ACCESS SHALL be ignored.
REQ-030 Outside their active states, mem_req, resp_valid, resp_we, fault SHALL be 0; resp_data/resp_rd SHALL be 0 when resp_valid=0.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and clear all registers; from the next cycle all outputs are 0 except req_ready=1.
REQ-032 rst during ACCESS SHALL abandon the access: mem_req=0 next cycle, no resp_valid, no fault for it.
REQ-033 rst SHALL override a simultaneous handshake or mem_ack.

Structure
REQ-034 Package lsu_pkg SHALL hold funct3 constants (LB..SW), the FSM state enum, and the byte-strobe width.
REQ-035 Sub-module lsu_align (combinational) SHALL compute store lane data/strobes and load extraction/extension; load_store_unit holds the FSM and registers.

Verification
REQ-036 LW addr=0x100, mem_rdata=0xDEADBEEF, ack 1 cycle after mem_req -> mem_addr=0x100, wstrb=0000, resp_data=0xDEADBEEF, resp_we=1, resp_valid at handshake+3.
REQ-037 LB addr=0x103, rdata=0x80112233 -> resp_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x00008011.
REQ-038 SB addr=0x201, wdata=0x000000A5 -> mem_addr=0x200, wstrb=0010, wdata=0xA5A5A5A5, resp_we=0; SH addr=0x202, wdata=0x1234 -> wstrb=1100, wdata=0x12341234.
REQ-039 LW addr=0x102 or funct3=011 -> fault pulse 1 cycle, mem_req never 1, req_ready back to 1 two cycles after handshake.
REQ-040 mem_ack withheld 5 cycles -> mem_* stable, req_ready=0 throughout; spurious mem_ack while IDLE -> no response.
REQ-041 rst asserted during ACCESS -> next cycle mem_req=0, req_ready=1, no resp_valid or fault ever produced for that request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states,
// strobe width and the request legality check.
package lsu_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_FAULT
    } lsu_state_e;

    // True when the opcode is legal for its direction and the address is
    // naturally aligned for the access size.
    function automatic logic req_ok(input logic       is_store,
                                    input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
        logic legal;
        logic aligned;
        if (is_store)
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        else
            legal = (funct3 == F3_LB)  || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        case (funct3[1:0])
            2'b01:   aligned = ~addr_lo[0];
            2'b10:   aligned = (addr_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication and strobes, load lane
// extraction with sign or zero extension. Purely combinational.
module lsu_align #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]                 funct3,
    input  logic [1:0]                 addr_lo,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [WIDTH-1:0]           rdata,
    output logic [WIDTH-1:0]           store_data,
    output logic [lsu_pkg::STRB_W-1:0] store_strb,
    output logic [WIDTH-1:0]           load_data
);
    import lsu_pkg::*;

    logic [WIDTH-1:0]  lane;
    logic [STRB_W-1:0] strb_one;

    assign strb_one = {{(STRB_W-1){1'b0}}, 1'b1};

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        store_data = wdata;
        store_strb = '1;
        case (funct3[1:0])
            2'b00: begin
                store_data = {(WIDTH/8){wdata[7:0]}};
                store_strb = strb_one << addr_lo;
            end
            2'b01: begin
                store_data = {(WIDTH/16){wdata[15:0]}};
                store_strb = {strb_one[STRB_W-2:0], 1'b1} << addr_lo;
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0; word loads are aligned, so the
    // shift is zero for them.
    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = lane;
        case (funct3)
            F3_LB:   load_data = {{(WIDTH-8){lane[7]}},   lane[7:0]};
            F3_LH:   load_data = {{(WIDTH-16){lane[15]}}, lane[15:0]};
            F3_LBU:  load_data = {{(WIDTH-8){1'b0}},      lane[7:0]};
            F3_LHU:  load_data = {{(WIDTH-16){1'b0}},     lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one memory op at a time, issues a single
// data-memory access, and returns a one-cycle writeback result or fault.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_is_store,
    input  logic [2:0]         req_funct3,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [4:0]         req_rd,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH/8-1:0] mem_wstrb,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic               mem_ack,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               resp_valid,
    output logic               resp_we,
    output logic [4:0]         resp_rd,
    output logic [WIDTH-1:0]   resp_data,
    output logic               fault
);
    import lsu_pkg::*;

    lsu_state_e        state, state_nxt;
    logic              handshake;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [WIDTH-1:0]  addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [4:0]        rd_q;
    logic [WIDTH-1:0]  load_q;
    logic [WIDTH-1:0]  store_data;
    logic [STRB_W-1:0] store_strb;
    logic [WIDTH-1:0]  load_data;

    assign handshake = req_valid && (state == ST_IDLE);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid)
                           state_nxt = req_ok(req_is_store, req_funct3, req_addr[1:0])
                                       ? ST_ACCESS : ST_FAULT;
            ST_ACCESS: if (mem_ack) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            ST_FAULT:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are held for the whole access; load data is captured
    // on the ack cycle so the response does not depend on mem_rdata later.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            load_q     <= '0;
        end else begin
            if (handshake) begin
                is_store_q <= req_is_store;
                funct3_q   <= req_funct3;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rd_q       <= req_rd;
            end
            if (state == ST_ACCESS && mem_ack)
                load_q <= load_data;
        end
    end

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .store_data (store_data),
        .store_strb (store_strb),
        .load_data  (load_data)
    );

    always_comb begin
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wstrb  = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_we    = 1'b0;
        resp_rd    = '0;
        resp_data  = '0;
        fault      = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_ACCESS: begin
                mem_req  = 1'b1;
                mem_we   = is_store_q;
                mem_addr = {addr_q[WIDTH-1:2], 2'b00};
                if (is_store_q) begin
                    mem_wstrb = store_strb;
                    mem_wdata = store_data;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (!is_store_q) begin
                    resp_we   = 1'b1;
                    resp_rd   = rd_q;
                    resp_data = load_q;
                end
            end
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized check of load_store_unit against a behavioural
// model of RV32I load/store lane rules and transaction timing.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        fault;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_we      (resp_we),
        .resp_rd      (resp_rd),
        .resp_data    (resp_data),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: plain arithmetic on the RV32I rules ----
    function automatic bit model_ok(input bit st, input bit [2:0] f3, input bit [31:0] addr);
        bit legal;
        int size;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        return legal && (addr % size == 0);
    endfunction

    function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [31:0] addr,
                                             input bit [31:0] rdata);
        bit [31:0] v;
        v = rdata >> (8 * (addr % 4));
        case (f3)
            3'd0: return (v % 256 >= 128)   ? (v % 256) + 32'hFFFF_FF00 : v % 256;
            3'd1: return (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
            3'd4: return v % 256;
            3'd5: return v % 65536;
            default: return rdata;
        endcase
    endfunction

    function automatic bit [31:0] model_sdata(input bit [2:0] f3, input bit [31:0] wdata);
        case (f3)
            3'd0:    return (wdata % 256) * 32'h0101_0101;
            3'd1:    return (wdata % 65536) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic bit [31:0] model_strb(input bit [2:0] f3, input bit [31:0] addr);
        case (f3)
            3'd0:    return 32'(1 << (addr % 4));
            3'd1:    return 32'(3 << (addr % 4));
            default: return 32'd15;
        endcase
    endfunction

    // One complete transaction from an IDLE cycle back to IDLE. wait_n is the
    // number of mem_req cycles before the ack cycle.
    task automatic do_op(input string nm, input bit st, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [31:0] wdata, input bit [4:0] rd,
                         input bit [31:0] rdata, input int wait_n);
        bit [31:0] e_load;
        check({nm, ".ready_before"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        step();
        // Scramble request inputs; the unit must work from captured copies.
        req_valid    = 1'b0;
        req_is_store = 1'($urandom);
        req_funct3   = 3'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_rd       = 5'($urandom);
        if (!model_ok(st, f3, addr)) begin
            check({nm, ".fault"},      32'(fault),      32'd1);
            check({nm, ".fault_mreq"}, 32'(mem_req),    32'd0);
            check({nm, ".fault_rv"},   32'(resp_valid), 32'd0);
            check({nm, ".fault_rdy"},  32'(req_ready),  32'd0);
            step();
            check({nm, ".fault_end"},  32'(fault),      32'd0);
            check({nm, ".ready_after"}, 32'(req_ready), 32'd1);
            check({nm, ".mreq_after"}, 32'(mem_req),    32'd0);
            return;
        end
        for (int i = 0; i <= wait_n; i++) begin
            mem_ack   = (i == wait_n);
            mem_rdata = (i == wait_n) ? rdata : $urandom;
            check({nm, ".mem_req"},   32'(mem_req),   32'd1);
            check({nm, ".mem_we"},    32'(mem_we),    32'(st));
            check({nm, ".mem_addr"},  mem_addr,       addr - addr % 4);
            check({nm, ".mem_wstrb"}, 32'(mem_wstrb), st ? model_strb(f3, addr) : 32'd0);
            if (st) check({nm, ".mem_wdata"}, mem_wdata, model_sdata(f3, wdata));
            check({nm, ".busy_rdy"},  32'(req_ready), 32'd0);
            check({nm, ".busy_rv"},   32'(resp_valid), 32'd0);
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        e_load    = model_load(f3, addr, rdata);
        check({nm, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({nm, ".resp_we"},    32'(resp_we),    32'(!st));
        check({nm, ".resp_rd"},    32'(resp_rd),    st ? 32'd0 : 32'(rd));
        check({nm, ".resp_data"},  resp_data,       st ? 32'd0 : e_load);
        check({nm, ".resp_mreq"},  32'(mem_req),    32'd0);
        check({nm, ".resp_fault"}, 32'(fault),      32'd0);
        step();
        check({nm, ".rv_end"},      32'(resp_valid), 32'd0);
        check({nm, ".rdata_end"},   resp_data,       32'd0);
        check({nm, ".ready_after"}, 32'(req_ready),  32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = '0;
        req_addr     = '0;
        req_wdata    = '0;
        req_rd       = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        step();
        step();
        rst = 1'b0;

        check("rst.req_ready",  32'(req_ready),  32'd1);
        check("rst.mem_req",    32'(mem_req),    32'd0);
        check("rst.mem_addr",   mem_addr,        32'd0);
        check("rst.mem_wstrb",  32'(mem_wstrb),  32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_data",  resp_data,       32'd0);
        check("rst.fault",      32'(fault),      32'd0);

        // Directed cases
        do_op("lw",      1'b0, F3_LW,  32'h100, 32'h0, 5'd7,  32'hDEAD_BEEF, 1);
        do_op("lb",      1'b0, F3_LB,  32'h103, 32'h0, 5'd3,  32'h8011_2233, 0);
        do_op("lbu",     1'b0, F3_LBU, 32'h103, 32'h0, 5'd4,  32'h8011_2233, 0);
        do_op("lhu",     1'b0, F3_LHU, 32'h102, 32'h0, 5'd5,  32'h8011_2233, 2);
        do_op("lh",      1'b0, F3_LH,  32'h102, 32'h0, 5'd6,  32'h8011_2233, 0);
        do_op("sb",      1'b1, F3_SB,  32'h201, 32'h0000_00A5, 5'd9, 32'h0, 0);
        do_op("sh",      1'b1, F3_SH,  32'h202, 32'h0000_1234, 5'd9, 32'h0, 1);
        do_op("sw",      1'b1, F3_SW,  32'h204, 32'hCAFE_F00D, 5'd1, 32'h0, 0);
        do_op("lw_mis",  1'b0, F3_LW,  32'h102, 32'h0, 5'd2,  32'h0, 0);
        do_op("ill011",  1'b0, 3'b011, 32'h100, 32'h0, 5'd2,  32'h0, 0);
        do_op("sh_mis",  1'b1, F3_SH,  32'h203, 32'h1, 5'd2,  32'h0, 0);
        do_op("st_ill",  1'b1, 3'b100, 32'h200, 32'h1, 5'd2,  32'h0, 0);
        do_op("lw_slow", 1'b0, F3_LW,  32'h400, 32'h0, 5'd31, 32'h1234_5678, 5);

        // Spurious ack while idle
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_ack.resp_valid", 32'(resp_valid), 32'd0);
            check("idle_ack.req_ready",  32'(req_ready),  32'd1);
            check("idle_ack.mem_req",    32'(mem_req),    32'd0);
        end
        mem_ack = 1'b0;

        // Reset during ACCESS, with a simultaneous ack that must lose
        req_valid  = 1'b1;
        req_is_store = 1'b0;
        req_funct3 = F3_LW;
        req_addr   = 32'h300;
        req_rd     = 5'd8;
        step();
        req_valid = 1'b0;
        check("rst_acc.in_access", 32'(mem_req), 32'd1);
        rst     = 1'b1;
        mem_ack = 1'b1;
        step();
        rst = 1'b0;
        check("rst_acc.mem_req",   32'(mem_req),   32'd0);
        check("rst_acc.req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst_acc.no_resp",  32'(resp_valid), 32'd0);
            check("rst_acc.no_fault", 32'(fault),      32'd0);
            step();
        end
        mem_ack = 1'b0;

        // Reset beats a simultaneous handshake
        req_valid = 1'b1;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 1'b0;
        check("rst_hs.req_ready", 32'(req_ready), 32'd1);
        check("rst_hs.mem_req",   32'(mem_req),   32'd0);
        step();
        check("rst_hs.mem_req2",  32'(mem_req),   32'd0);

        // Randomized ops against the model
        for (int k = 0; k < 60; k++) begin
            bit        st;
            bit [2:0]  f3;
            bit [31:0] addr;
            st   = 1'($urandom);
            f3   = st ? 3'($urandom_range(0, 3)) : 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0)
                addr = addr - addr % ((f3 % 4 == 2) ? 4 : (f3 % 4 == 1) ? 2 : 1);
            do_op($sformatf("rnd%0d", k), st, f3, addr, $urandom, 5'($urandom),
                  $urandom, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
